scan_sel_gen: RTL and testbench

Sequencing stage that drives the 2-bit select inputs `a`/`b` of the 2-to-4 one-hot decoder. It steps through the four decoder channels in ascending order, skips masked-off channels and holds each selected channel for a programmable number of clock cycles. It runs once or continuously, and flags start of sweep, each step and sweep completion.

---
 rtl/scan_pkg.sv | 38 +++
 rtl/scan_dwell_cnt.sv | 33 +++
 rtl/scan_sel_gen.sv | 125 ++++++++++++
 tb/tb_scan_sel_gen.sv | 138 +++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and channel-search helpers for the decoder select sequencer.
package scan_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } sel_t;

    // Scanning downwards leaves the lowest qualifying channel in the result.
    function automatic sel_t next_en(input logic [NUM_CH-1:0] mask, input logic [1:0] idx);
        sel_t r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i > int'(idx) && mask[i]) begin
                r.found = 1'b1;
                r.idx   = i[1:0];
            end
        end
        return r;
    endfunction

    function automatic logic [1:0] first_en(input logic [NUM_CH-1:0] mask);
        logic [1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) r = i[1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_dwell_cnt.sv
// Loadable down-counter that times how long each channel stays selected.
module scan_dwell_cnt #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_val_i,
    input  logic               dec_i,
    output logic               zero_o
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/scan_sel_gen.sv
// Steps the 2-bit decoder select through enabled channels, holding each for dwell+1 cycles.
module scan_sel_gen #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [3:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               valid,
    output logic               step,
    output logic               busy,
    output logic               done
);

    import scan_pkg::*;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic               mode_q, mode_d;
    logic [3:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               step_q, step_d;
    logic               done_q, done_d;

    logic               cnt_load, cnt_dec, cnt_zero;
    logic [DWELL_W-1:0] cnt_val;
    sel_t               nxt;

    scan_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    assign nxt = next_en(mask_q, idx_q);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mode_d   = mode_q;
        mask_d   = mask_q;
        dwell_d  = dwell_q;
        step_d   = 1'b0;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = dwell_q;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && mask != 4'b0000) begin
                    state_d  = RUN;
                    mode_d   = mode;
                    mask_d   = mask;
                    dwell_d  = dwell;
                    idx_d    = first_en(mask);
                    cnt_load = 1'b1;
                    cnt_val  = dwell;
                    step_d   = 1'b1;
                end
            end
            RUN: begin
                // Abort wins over expiry; the counter is parked at zero either way.
                if (stop) begin
                    state_d  = IDLE;
                    idx_d    = '0;
                    cnt_load = 1'b1;
                    cnt_val  = '0;
                end else if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (nxt.found) begin
                    idx_d    = nxt.idx;
                    cnt_load = 1'b1;
                    step_d   = 1'b1;
                end else if (mode_q) begin
                    idx_d    = first_en(mask_q);
                    cnt_load = 1'b1;
                    step_d   = 1'b1;
                end else begin
                    state_d  = IDLE;
                    idx_d    = '0;
                    cnt_load = 1'b1;
                    cnt_val  = '0;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            mask_q  <= '0;
            dwell_q <= '0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    assign a     = idx_q[1];
    assign b     = idx_q[0];
    assign valid = (state_q == RUN);
    assign busy  = (state_q == RUN);
    assign step  = step_q;
    assign done  = done_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Directed vector bench for scan_sel_gen; expected outputs are {a,b,valid,step,busy,done}.
module tb_scan_sel_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, mode;
    logic [3:0] mask;
    logic [7:0] dwell;
    logic       a, b, valid, step, busy, done;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic       start;
        logic       stop;
        logic       mode;
        logic [3:0] mask;
        logic [7:0] dwell;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    scan_sel_gen #(.DWELL_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .mask  (mask),
        .dwell (dwell),
        .a     (a),
        .b     (b),
        .valid (valid),
        .step  (step),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {a, b, valid, step, busy, done};
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got {a,b,valid,step,busy,done}=%b, expected %b", name, got, exp);
        end
    endtask

    task automatic add(input logic st, input logic sp, input logic md, input logic [3:0] mk,
                       input logic [7:0] dw, input logic [5:0] exp);
        vec_t v;
        v.start = st; v.stop = sp; v.mode = md; v.mask = mk; v.dwell = dw; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        // start with empty mask is ignored
        add(1, 0, 0, 4'b0000, 8'd2, 6'b000000);
        add(0, 0, 0, 4'b0000, 8'd2, 6'b000000);
        // one-shot full sweep, dwell=2
        add(1, 0, 0, 4'b1111, 8'd2, 6'b001110);
        add(0, 0, 0, 4'b1111, 8'd2, 6'b001010);
        add(0, 0, 0, 4'b1111, 8'd2, 6'b001010);
        add(0, 0, 0, 4'b1111, 8'd2, 6'b011110);
        add(0, 0, 0, 4'b1111, 8'd2, 6'b011010);
        add(0, 0, 0, 4'b1111, 8'd2, 6'b011010);
        add(0, 0, 0, 4'b1111, 8'd2, 6'b101110);
        // ignored start plus live input changes during RUN
        add(1, 0, 1, 4'b0001, 8'd0, 6'b101010);
        add(1, 0, 1, 4'b0001, 8'd0, 6'b101010);
        add(0, 0, 1, 4'b0001, 8'd0, 6'b111110);
        add(0, 0, 1, 4'b0001, 8'd0, 6'b111010);
        add(0, 0, 1, 4'b0001, 8'd0, 6'b111010);
        add(0, 0, 0, 4'b0001, 8'd0, 6'b000001);
        // restart in the done cycle: continuous, mask 1010, dwell 0
        add(1, 0, 1, 4'b1010, 8'd0, 6'b011110);
        add(0, 0, 0, 4'b0000, 8'd5, 6'b111110);
        add(0, 0, 0, 4'b0000, 8'd5, 6'b011110);
        add(0, 0, 0, 4'b0000, 8'd5, 6'b111110);
        add(0, 0, 0, 4'b0000, 8'd5, 6'b011110);
        // stop coinciding with start: start still ignored
        add(1, 1, 1, 4'b1111, 8'd0, 6'b000000);
        add(0, 0, 0, 4'b0000, 8'd0, 6'b000000);
        add(1, 0, 1, 4'b1010, 8'd0, 6'b011110);
        add(0, 1, 0, 4'b0000, 8'd0, 6'b000000);
        // single channel, continuous, stop exactly at counter expiry
        add(1, 0, 1, 4'b0100, 8'd1, 6'b101110);
        add(0, 0, 1, 4'b0100, 8'd1, 6'b101010);
        add(0, 1, 1, 4'b0100, 8'd1, 6'b000000);
        add(0, 0, 1, 4'b0100, 8'd1, 6'b000000);
        add(1, 0, 1, 4'b0110, 8'd1, 6'b011110);
        add(0, 0, 1, 4'b0110, 8'd1, 6'b011010);
        add(0, 0, 1, 4'b0110, 8'd1, 6'b101110);
        add(0, 0, 1, 4'b0110, 8'd1, 6'b101010);
        add(0, 0, 1, 4'b0110, 8'd1, 6'b011110);
        add(0, 0, 1, 4'b0110, 8'd1, 6'b011010);
        add(0, 0, 1, 4'b0110, 8'd3, 6'b101110);

        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; mask = '0; dwell = '0;
        #2;
        check("reset_async", outs(), 6'b000000);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", outs(), 6'b000000);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].start; stop = vecs[i].stop; mode = vecs[i].mode;
            mask  = vecs[i].mask;  dwell = vecs[i].dwell;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // async reset mid-dwell while {a,b}=10
        start = 1'b0; stop = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_dwell", outs(), 6'b000000);
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst%0d", i), outs(), 6'b000000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
